melody_scheduler: RTL and testbench
===================================

# melody_scheduler

Sequences and arbitrates the 11-bit `frequency` input of the square-wave tone generator. It plays a stored song from a synchronous note ROM, one note at a time, with timed durations and inter-note gaps. When no song is playing, it passes live keyboard notes straight through. It sits between the keyboard/mode-control logic and the tone generator; frequency code 1 means silence.

## Interface
- `UNIT_CYCLES`, 12_500_000: clock cycles per duration unit (1/8 s at 100 MHz).
- `GAP_CYCLES`, 1_250_000: silent cycles inserted after each song note; 0 means no gap.
- `ADDR_W`, 5: ROM address width; song length is at most 2^ADDR_W notes.

Ports:
- `clk`, in, 1: system clock. One clock only.
- `rst`, in, 1: synchronous, active-high reset.
- `key_freq`, in, 11: live keyboard frequency.
- `key_valid`, in, 1: a key is held.
- `play`, in, 1: start the song (level-sampled).
- `stop`, in, 1: abort the song.
- `rom_addr`, out, ADDR_W: note ROM address (registered).
- `rom_data`, in, 16: `{dur[4:0], freq[10:0]}`; valid the cycle after `rom_addr` changes.
- `frequency`, out, 11: to the tone generator (registered).
- `playing`, out, 1: song in progress.
- `done`, out, 1: one-cycle pulse at song end (natural end or stop).

## Operation
- Reset values: `frequency`=1, `playing`=0, `done`=0, `rom_addr`=0. State is IDLE and all counters are 0.
- States are IDLE, LOAD, LATCH, SOUND, GAP.
- IDLE:
  - `frequency` ← (`key_valid` && `key_freq`≠0) ? `key_freq` : 1.
  - `key_freq`=0 is forced to 1, so the generator never sees 0.
  - On `play` && !`stop`: `rom_addr`←0, `playing`←1, go to LOAD.
- LOAD: wait one cycle for the ROM, then go to LATCH. `frequency` keeps its previous value.
- LATCH: sample `rom_data`.
  - If `dur`=0 (end marker), end the song.
  - Otherwise `frequency`←`freq` (0 is mapped to 1), duration counter ← `dur`×`UNIT_CYCLES`−1, go to SOUND.
- SOUND: decrement the counter each cycle. At 0:
  - If `GAP_CYCLES`>0: `frequency`←1, gap counter ← `GAP_CYCLES`−1, go to GAP.
  - Else: advance.
- GAP: decrement. At 0, advance.
- Advance:
  - If `rom_addr` = 2^ADDR_W−1, end the song. There is no wrap-around.
  - Otherwise `rom_addr`←`rom_addr`+1, go to LOAD.
- End song: `frequency`←1, `playing`←0, `done` pulses for 1 cycle, `rom_addr`←0, go to IDLE.
- `stop` in any non-IDLE state: end the song on the next edge, with the same outputs as a natural end. `stop` in IDLE has no effect and `done` is not pulsed.
- `play` and `stop` in the same cycle: `stop` wins, and nothing starts.
- `play` while `playing`=1: ignored. A `play` held high after the song ends restarts it from IDLE.
- Keyboard input is ignored while `playing`=1, unless the configuration macro below is defined.
- Duration arithmetic: the product is 32 bits wide. `dur`≤31 and `UNIT_CYCLES`<2^27 are required.
- `rst` asserted mid-song returns everything to reset values on the next edge. `done` is not pulsed.

## Timing
- Keyboard path: `frequency` follows `key_freq`/`key_valid` with 1-cycle latency.
- Play sampled in cycle t:
  - LOAD in t+1; LATCH in t+2.
  - First note appears on `frequency` in t+3.
  - `playing`=1 from t+1.
- Note k occupies `dur`×`UNIT_CYCLES` cycles.
- Gap: `GAP_CYCLES` cycles.
- Next-note fetch overhead: 2 cycles (LOAD, LATCH), holding `frequency`=1 (or the note, if there is no gap).
- End marker: `done` pulses in the cycle after LATCH. `playing` falls in that same cycle.

## Configuration
- `KEY_PREEMPT_EN` defined: `key_valid`=1 with `key_freq`≠0 during any non-IDLE state behaves as `stop`. The song ends with a `done` pulse, and the next IDLE cycle passes the key through.
- Not defined: keys are ignored during a song, and only `stop` or `rst` aborts it.

## Test plan
- Reset, then `key_valid`=1, `key_freq`=523 → `frequency`=523 one cycle later. `key_freq`=0 → `frequency`=1.
- ROM = {(2,262),(1,294),(0,x)}, `UNIT_CYCLES`=4, `GAP_CYCLES`=2, `play` pulse at t:
  - `frequency`=262 for 8 cycles from t+3, then 1 for 4 cycles (2 gap + 2 fetch), then 294 for 4 cycles.
  - Gap and fetch follow, then `done` pulses and `playing`=0.
- ROM filled with non-zero durations, `ADDR_W`=2 → exactly 4 notes play, then `done`, with `rom_addr` back at 0.
- `stop` mid-SOUND → next cycle `frequency`=1, `playing`=0, `done`=1. `play`+`stop` together in IDLE → nothing starts.
- `rst` asserted during GAP → all outputs at reset values next cycle, no `done`.
- With `KEY_PREEMPT_EN`, `key_valid` during a song → song aborts with `done`. Without it, the key is ignored and the song completes.

Source files
------------

// File: rtl/melody_scheduler.sv
// melody_scheduler: plays a ROM song onto the tone-generator frequency, passing keyboard notes through when idle.
// Optional KEY_PREEMPT_EN: a held key during a song aborts it like stop.
module melody_scheduler #(
   parameter int UNIT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_250_000,
   parameter int ADDR_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [10:0]       key_freq,
   input  logic              key_valid,
   input  logic              play,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [10:0]       frequency,
   output logic              playing,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, LOAD, LATCH, SOUND, GAP} state_t;
   state_t      r_state;
   logic [31:0] r_cnt;
   logic [4:0]  w_dur;
   logic [10:0] w_note, w_key;
   logic        w_key_on, w_abort, w_cnt0, w_adv, w_end;
   assign w_dur    = rom_data[15:11];
   assign w_note   = rom_data[10:0] == 11'd0 ? 11'd1 : rom_data[10:0];
   assign w_key_on = key_valid && key_freq != 11'd0;
   assign w_key    = w_key_on ? key_freq : 11'd1;
`ifdef KEY_PREEMPT_EN
   assign w_abort  = stop || w_key_on;
`else
   assign w_abort  = stop;
`endif
   assign w_cnt0   = r_cnt == 32'd0;
   // A finished note (no gap) or a finished gap moves on to the next address
   assign w_adv    = w_cnt0 && (r_state == GAP || (r_state == SOUND && GAP_CYCLES == 0));
   assign w_end    = r_state != IDLE && (w_abort || (r_state == LATCH && w_dur == 5'd0) || (w_adv && &rom_addr));
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 32'd0;
         rom_addr  <= '0;
         frequency <= 11'd1;
         playing   <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= w_end;
         if (w_end) begin
            r_state   <= IDLE;
            r_cnt     <= 32'd0;
            rom_addr  <= '0;
            frequency <= 11'd1;
            playing   <= 1'b0;
         end else if (w_adv) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            r_state  <= LOAD;
         end else begin
            case (r_state)
               LOAD: r_state <= LATCH;
               LATCH: begin
                  frequency <= w_note;
                  r_cnt     <= 32'(w_dur) * 32'(UNIT_CYCLES) - 32'd1;
                  r_state   <= SOUND;
               end
               SOUND: begin
                  r_cnt     <= w_cnt0 ? 32'(GAP_CYCLES - 1) : r_cnt - 32'd1;
                  frequency <= w_cnt0 ? 11'd1 : frequency;
                  r_state   <= w_cnt0 ? GAP : SOUND;
               end
               GAP: r_cnt <= r_cnt - 32'd1;
               default: begin
                  frequency <= w_key;
                  if (play && !stop) begin
                     rom_addr <= '0;
                     playing  <= 1'b1;
                     r_state  <= LOAD;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_melody_scheduler.sv
// tb_melody_scheduler: per-cycle timeline model of the song schedule plus directed literal checks and random stimulus.
module tb_melody_scheduler;
   localparam int U = 4;
   localparam int G = 2;
   typedef struct packed {
      logic [10:0] f;
      logic        p;
      logic        d;
      logic [1:0]  a;
      logic        b;
   } ent_t;
   localparam ent_t END_E = {11'd1, 1'b0, 1'b1, 2'd0, 1'b0};
   localparam ent_t RST_E = {11'd1, 1'b0, 1'b0, 2'd0, 1'b0};
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] key_freq = '0;
   logic        key_valid = 1'b0;
   logic        play = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  rom_addr;
   logic [15:0] rom_data = '0;
   logic [10:0] frequency;
   logic        playing, done;
   logic [15:0] rom [4];
   ent_t        cur = RST_E;
   ent_t        q [$];
   bit          chk_en = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   melody_scheduler #(.UNIT_CYCLES(U), .GAP_CYCLES(G), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst), .key_freq(key_freq), .key_valid(key_valid), .play(play), .stop(stop),
      .rom_addr(rom_addr), .rom_data(rom_data), .frequency(frequency), .playing(playing), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] key_w();
      return (key_valid && key_freq != 11'd0) ? key_freq : 11'd1;
   endfunction

   function automatic logic abort_w();
`ifdef KEY_PREEMPT_EN
      return stop || (key_valid && key_freq != 11'd0);
`else
      return stop;
`endif
   endfunction

   // Lay out every output cycle of the song from the ROM contents, ending with the done cycle
   task automatic build(input logic [10:0] k);
      logic [10:0] hold, f;
      int d;
      hold = k;
      q.delete();
      for (int i = 0; i < 4; i++) begin
         q.push_back({hold, 1'b1, 1'b0, 2'(i), 1'b1});
         q.push_back({hold, 1'b1, 1'b0, 2'(i), 1'b1});
         d = int'(rom[i][15:11]);
         f = rom[i][10:0] == 11'd0 ? 11'd1 : rom[i][10:0];
         if (d == 0) begin
            q.push_back(END_E);
            return;
         end
         for (int j = 0; j < d * U; j++) q.push_back({f, 1'b1, 1'b0, 2'(i), 1'b1});
         for (int j = 0; j < G; j++) q.push_back({11'd1, 1'b1, 1'b0, 2'(i), 1'b1});
         hold = G > 0 ? 11'd1 : f;
      end
      q.push_back(END_E);
   endtask

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         cur = RST_E;
      end else if (cur.b) begin
         if (abort_w()) begin
            q.delete();
            cur = END_E;
         end else cur = q.pop_front();
      end else if (play && !stop) begin
         build(key_w());
         cur = q.pop_front();
      end else cur = {key_w(), 1'b0, 1'b0, 2'd0, 1'b0};
   end

   always @(negedge clk) if (chk_en) begin
      chk("m_freq", 32'(frequency), 32'(cur.f));
      chk("m_playing", 32'(playing), 32'(cur.p));
      chk("m_done", 32'(done), 32'(cur.d));
      chk("m_addr", 32'(rom_addr), 32'(cur.a));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start();
      play = 1'b1;
      step();
      play = 1'b0;
   endtask

   initial begin
      int notes, maxa, k;
      logic [10:0] prev;
      bit seen;
      for (int i = 0; i < 4; i++) rom[i] = '0;
      step();
      chk_en = 1'b1;
      rst = 1'b0;
      chk("rst_freq", 32'(frequency), 1);
      chk("rst_playing", 32'(playing), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_addr", 32'(rom_addr), 0);
      key_valid = 1'b1; key_freq = 11'd523;
      step();
      chk("key_523", 32'(frequency), 523);
      key_freq = 11'd0;
      step();
      chk("key_zero", 32'(frequency), 1);
      key_valid = 1'b0;
      step();
      rom[0] = {5'd2, 11'd262}; rom[1] = {5'd1, 11'd294}; rom[2] = '0; rom[3] = {5'd1, 11'd999};
      start();
      chk("song_t1_playing", 32'(playing), 1);
      repeat (2) step();
      chk("song_t3", 32'(frequency), 262);
      repeat (7) step();
      chk("song_t10", 32'(frequency), 262);
      step();
      chk("song_t11", 32'(frequency), 1);
      repeat (3) step();
      chk("song_t14", 32'(frequency), 1);
      step();
      chk("song_t15", 32'(frequency), 294);
      repeat (3) step();
      chk("song_t18", 32'(frequency), 294);
      repeat (4) step();
      chk("song_t22_playing", 32'(playing), 1);
      step();
      chk("song_done", 32'(done), 1);
      chk("song_end_playing", 32'(playing), 0);
      step();
      chk("song_done_once", 32'(done), 0);
      rom[0] = {5'd1, 11'd100}; rom[1] = {5'd1, 11'd200}; rom[2] = {5'd1, 11'd300}; rom[3] = {5'd1, 11'd400};
      start();
      notes = 0; maxa = 0; prev = frequency; seen = 1'b0;
      for (k = 0; k < 200 && !seen; k++) begin
         if (frequency != prev && frequency != 11'd1) notes++;
         prev = frequency;
         if (int'(rom_addr) > maxa) maxa = int'(rom_addr);
         if (done) seen = 1'b1;
         else step();
      end
      chk("full_done_seen", 32'(seen), 1);
      chk("full_notes", 32'(notes), 4);
      chk("full_max_addr", 32'(maxa), 3);
      chk("full_addr_back", 32'(rom_addr), 0);
      step();
      rom[0] = {5'd5, 11'd500};
      start();
      repeat (4) step();
      chk("stop_sounding", 32'(frequency), 500);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_freq", 32'(frequency), 1);
      chk("stop_playing", 32'(playing), 0);
      chk("stop_done", 32'(done), 1);
      step();
      chk("stop_done_once", 32'(done), 0);
      play = 1'b1; stop = 1'b1;
      step();
      play = 1'b0; stop = 1'b0;
      chk("ps_playing", 32'(playing), 0);
      step();
      chk("ps_playing2", 32'(playing), 0);
      chk("ps_done", 32'(done), 0);
      rom[0] = {5'd1, 11'd700}; rom[1] = {5'd1, 11'd710};
      start();
      repeat (14) step();
      chk("gap_addr", 32'(rom_addr), 1);
      chk("gap_freq", 32'(frequency), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("grst_freq", 32'(frequency), 1);
      chk("grst_playing", 32'(playing), 0);
      chk("grst_done", 32'(done), 0);
      chk("grst_addr", 32'(rom_addr), 0);
      step();
      chk("grst_no_done", 32'(done), 0);
      rom[0] = {5'd3, 11'd800}; rom[1] = '0;
      start();
      repeat (4) step();
      key_valid = 1'b1; key_freq = 11'd523;
      step();
      key_valid = 1'b0;
`ifdef KEY_PREEMPT_EN
      chk("kp_done", 32'(done), 1);
      chk("kp_playing", 32'(playing), 0);
`else
      chk("kp_ignored_done", 32'(done), 0);
      chk("kp_ignored_freq", 32'(frequency), 800);
      seen = 1'b0;
      for (k = 0; k < 100 && !seen; k++) begin
         step();
         if (done) seen = 1'b1;
      end
      chk("kp_song_completes", 32'(seen), 1);
`endif
      step();
      for (int c = 0; c < 4000; c++) begin
         if (!cur.b && $urandom_range(3) == 0)
            for (int i = 0; i < 4; i++)
               rom[i] = {5'($urandom_range(3)), $urandom_range(7) == 0 ? 11'd0 : 11'($urandom)};
         rst       = $urandom_range(499) == 0;
         stop      = $urandom_range(79) == 0;
         play      = $urandom_range(5) == 0;
         key_valid = $urandom_range(9) == 0;
         key_freq  = $urandom_range(9) == 0 ? 11'd0 : 11'($urandom);
         step();
      end
      rst = 1'b0; stop = 1'b0; play = 1'b0; key_valid = 1'b0;
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
